rob_commit: RTL and testbench
=============================

// Module: rob_commit
// PURPOSE
//  Retire stage directly downstream of the ROB. Inspects the ROB head pair (two channels, popped
//  together), commits completed instructions in order to the architectural register file, issues
//  committed stores to the D-side, and raises flush/redirect on exceptions and branch mispredicts.
//  MIPS delay-slot semantics: a branch occupies slot 0, its delay slot occupies slot 1 of the same pair.
// PARAMETERS
//  DATA_W   32  register/PC data width
//  REG_W    5   architectural register index width (0 = $zero, never written)
//  CNT_W    32  width of retired-instruction counter
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous, active-low reset (rst==0 resets on rising clk)
//  rob_empty      in   1        ROB has no pair at head
//  hd_valid       in   2        per-slot: slot holds an instruction (slot1 may be a bubble)
//  hd_done        in   2        per-slot: result written back (CDB seen)
//  hd_ex          in   2        per-slot: exception recorded
//  hd_mispred     in   2        per-slot: branch resolved mispredicted (only slot0 legal)
//  hd_store       in   2        per-slot: store instruction (at most one per pair)
//  hd_dest        in   2xREG_W  per-slot destination register
//  hd_data        in   2xDATA_W per-slot result
//  hd_pc          in   2xDATA_W per-slot PC
//  hd_target      in   DATA_W   correct target of slot0 branch
//  rob_pop        out  1        pop head pair this cycle
//  rf_we          out  2        architectural register-file write enables
//  rf_waddr       out  2xREG_W  write addresses
//  rf_wdata       out  2xDATA_W write data
//  store_req      out  1        commit buffered store to D-side
//  store_ack      in   1        D-side accepted store
//  flush          out  1        pipeline + ROB flush pulse
//  redirect_pc    out  DATA_W   fetch restart PC, valid with flush
//  exc_valid      out  1        exception taken (with flush)
//  exc_epc        out  DATA_W   PC of faulting instruction
//  retired_cnt    out  CNT_W    running count of committed instructions
// BEHAVIOUR
//  Reset: state=RUN; rob_pop, rf_we, store_req, flush, exc_valid = 0; redirect_pc, exc_epc,
//   retired_cnt = 0. All outputs except retired_cnt/redirect_pc/exc_epc are combinational from
//   state + head; those three and flush are registered.
//  Pair ready: !rob_empty && all valid slots done. Nothing happens while not ready.
//  States: RUN, WAIT_STORE, FLUSH.
//  RUN, ready, no ex, no store: rob_pop=1; rf_we[i]=hd_valid[i] && hd_dest[i]!=0; retired_cnt +=
//   popcount(hd_valid). If hd_mispred[0]: both slots commit (delay slot retires), next cycle
//   flush=1, redirect_pc=hd_target; go FLUSH.
//  RUN, ready, hd_ex[0]: no rf writes, no store, rob_pop=0; next cycle flush=1, exc_valid=1,
//   exc_epc=hd_pc[0], redirect_pc=hd_pc[0] (handler vectoring is downstream); go FLUSH.
//  RUN, ready, hd_ex[1] && !hd_ex[0]: slot0 commits alone (rf_we[0] only, store of slot0 allowed
//   via WAIT_STORE first), retired_cnt+=1, rob_pop=1; next cycle flush/exc with epc=hd_pc[1].
//  RUN, ready, store in a non-faulting slot ahead of/at any fault: store_req=1, no pop, no rf write;
//   if store_ack same cycle, commit as above immediately; else go WAIT_STORE.
//  WAIT_STORE: store_req held 1 with stable head; on store_ack commit pair (same rules, no
//   re-issue), return RUN (or FLUSH path). store_req never dropped before ack.
//  FLUSH: flush/exc_valid are single-cycle pulses; rob_pop=0, rf_we=0 while flush=1; head inputs
//   ignored; return to RUN next cycle.
//  Precedence: ex in slot0 > ex in slot1 > mispredict. Mispredict in slot1 is illegal (assertion).
//  retired_cnt wraps modulo 2^CNT_W.
//  Reset mid-WAIT_STORE: drop store_req immediately on the reset edge; no pop; counter cleared.
//  Writes to $zero suppressed; both slots to same dest: slot1 value wins (rf port 1 priority).
// TESTING
//  Pair {add r3=5, add r4=7}, both done -> 1 cycle: rob_pop=1, rf_we=2'b11, retired_cnt 0->2.
//  Slot0 done, slot1 not done for 3 cycles -> rob_pop=0 for 3 cycles, commit on 4th.
//  Slot0 store, store_ack after 4 cycles -> store_req high 4 cycles, pop+rf_we on ack cycle only.
//  Slot1 ex (pc=0x80000104), slot0 add r2 -> rf_we=2'b01, pop, next cycle flush=1, exc_epc=0x80000104.
//  Slot0 mispredict branch, target 0xBFC00200 -> both commit, next cycle flush=1, redirect_pc=0xBFC00200.
//  rst=0 during WAIT_STORE -> next cycle store_req=0, retired_cnt=0, state RUN.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: in-order retire stage behind the ROB head pair.
//
// Looks at the two-slot ROB head (slot 0 older, slot 1 is the delay slot
// when slot 0 is a branch). It commits completed instructions to the
// architectural register file and hands committed stores to the D-side. On
// an exception or a slot-0 mispredict it raises a one-cycle flush with a
// restart PC.
//
// Ports
//   clk, rst           clock, synchronous active-low reset
//   rob_empty          no pair present at the ROB head
//   hd_valid/done/ex/mispred/store  per-slot head status (bit i = slot i)
//   hd_dest/data/pc    per-slot destination, result and PC (slot i at [i*W +: W])
//   hd_target          correct target of a slot-0 branch
//   rob_pop            pop the head pair
//   rf_we/waddr/wdata  two architectural register-file write ports
//   store_req/ack      store handshake with the D-side
//   flush, redirect_pc flush pulse and fetch restart PC
//   exc_valid, exc_epc exception taken, PC of faulting instruction
//   retired_cnt        committed-instruction counter (wraps)
//
// state        | meaning
// S_RUN        | inspecting the head pair each cycle
// S_WAIT_STORE | store issued, holding store_req until store_ack
// S_FLUSH      | one-cycle flush / exception pulse, head ignored
module rob_commit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rob_empty,
  input  logic [1:0]          hd_valid,
  input  logic [1:0]          hd_done,
  input  logic [1:0]          hd_ex,
  input  logic [1:0]          hd_mispred,
  input  logic [1:0]          hd_store,
  input  logic [2*REG_W-1:0]  hd_dest,
  input  logic [2*DATA_W-1:0] hd_data,
  input  logic [2*DATA_W-1:0] hd_pc,
  input  logic [DATA_W-1:0]   hd_target,
  output logic                rob_pop,
  output logic [1:0]          rf_we,
  output logic [2*REG_W-1:0]  rf_waddr,
  output logic [2*DATA_W-1:0] rf_wdata,
  output logic                store_req,
  input  logic                store_ack,
  output logic                flush,
  output logic [DATA_W-1:0]   redirect_pc,
  output logic                exc_valid,
  output logic [DATA_W-1:0]   exc_epc,
  output logic [CNT_W-1:0]    retired_cnt
);

  typedef enum logic [1:0] {S_RUN, S_WAIT_STORE, S_FLUSH} state_t;

  state_t              r_state;
  logic                r_exc;
  logic [DATA_W-1:0]   r_redirect;
  logic [DATA_W-1:0]   r_epc;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_ready;
  logic                w_ex0;
  logic                w_ex1;
  logic                w_mis;
  logic [1:0]          w_cmask;
  logic                w_need_store;
  logic [CNT_W-1:0]    w_ncommit;
  logic                w_run_ready;
  logic                w_waiting;
  logic                w_commit;

  always_comb begin
    w_ready  = !rob_empty && ((hd_valid & ~hd_done) == 2'b00);
    w_ex0    = hd_valid[0] & hd_ex[0];
    w_ex1    = hd_valid[1] & hd_ex[1] & ~w_ex0;
    w_mis    = hd_valid[0] & hd_mispred[0];
    // Slots that retire: everything older than the first fault.
    if (w_ex0)      w_cmask = 2'b00;
    else if (w_ex1) w_cmask = {1'b0, hd_valid[0]};
    else            w_cmask = hd_valid;
    w_need_store = |(w_cmask & hd_store);
    w_ncommit    = CNT_W'(w_cmask[0]) + CNT_W'(w_cmask[1]);
    // Gating with rst drops store_req and pops as soon as reset is applied.
    w_run_ready  = rst && (r_state == S_RUN) && w_ready;
    w_waiting    = rst && (r_state == S_WAIT_STORE);
    store_req    = w_waiting || (w_run_ready && w_need_store);
    w_commit     = (w_waiting && store_ack) ||
                   (w_run_ready && !w_ex0 && (!w_need_store || store_ack));
    rob_pop      = w_commit;
    rf_we[0]     = w_commit && w_cmask[0] && (hd_dest[0 +: REG_W] != '0);
    rf_we[1]     = w_commit && w_cmask[1] && (hd_dest[REG_W +: REG_W] != '0);
  end

  assign rf_waddr    = hd_dest;
  assign rf_wdata    = hd_data;
  assign flush       = (r_state == S_FLUSH);
  assign exc_valid   = (r_state == S_FLUSH) && r_exc;
  assign redirect_pc = r_redirect;
  assign exc_epc     = r_epc;
  assign retired_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_RUN;
      r_exc      <= 1'b0;
      r_redirect <= '0;
      r_epc      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_RUN, S_WAIT_STORE: begin
          if (w_commit) begin
            r_cnt <= r_cnt + w_ncommit;
            if (w_ex1) begin
              r_state    <= S_FLUSH;
              r_exc      <= 1'b1;
              r_epc      <= hd_pc[DATA_W +: DATA_W];
              r_redirect <= hd_pc[DATA_W +: DATA_W];
            end else if (w_mis) begin
              // Delay slot has already retired alongside the branch.
              r_state    <= S_FLUSH;
              r_exc      <= 1'b0;
              r_redirect <= hd_target;
            end else begin
              r_state <= S_RUN;
            end
          end else if (w_run_ready && w_ex0) begin
            r_state    <= S_FLUSH;
            r_exc      <= 1'b1;
            r_epc      <= hd_pc[0 +: DATA_W];
            r_redirect <= hd_pc[0 +: DATA_W];
          end else if (w_run_ready && w_need_store) begin
            r_state <= S_WAIT_STORE;
          end
        end
        S_FLUSH: begin
          r_state <= S_RUN;
          r_exc   <= 1'b0;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Only slot 0 may hold a branch, and a pair carries at most one store.
  a_no_mispred_slot1: assert property (@(posedge clk) disable iff (!rst)
    !(!rob_empty && hd_valid[1] && hd_mispred[1]));
  a_one_store: assert property (@(posedge clk) disable iff (!rst)
    !(!rob_empty && (&(hd_valid & hd_store))));

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          rob_empty;
  logic [1:0]    hd_valid, hd_done, hd_ex, hd_mispred, hd_store;
  logic [2*RW-1:0] hd_dest;
  logic [2*DW-1:0] hd_data, hd_pc;
  logic [DW-1:0] hd_target;
  logic          rob_pop;
  logic [1:0]    rf_we;
  logic [2*RW-1:0] rf_waddr;
  logic [2*DW-1:0] rf_wdata;
  logic          store_req, store_ack;
  logic          flush, exc_valid;
  logic [DW-1:0] redirect_pc, exc_epc;
  logic [CW-1:0] retired_cnt;

  rob_commit #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rob_empty(rob_empty),
    .hd_valid(hd_valid), .hd_done(hd_done), .hd_ex(hd_ex),
    .hd_mispred(hd_mispred), .hd_store(hd_store), .hd_dest(hd_dest),
    .hd_data(hd_data), .hd_pc(hd_pc), .hd_target(hd_target),
    .rob_pop(rob_pop), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .store_req(store_req), .store_ack(store_ack), .flush(flush),
    .redirect_pc(redirect_pc), .exc_valid(exc_valid), .exc_epc(exc_epc),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: architectural view of the retire stage.
  logic          m_waiting   = 1'b0;
  logic          m_flush_now = 1'b0;
  logic          m_exc_now   = 1'b0;
  logic [DW-1:0] m_redirect  = '0;
  logic [DW-1:0] m_epc       = '0;
  logic [CW-1:0] m_cnt       = '0;
  logic          m_new_head  = 1'b1;

  task automatic step();
    logic e_pop, e_sreq, e_flush, e_exc, commit_now, sched, s_exc, rdy, st, nwait;
    logic [1:0] e_we, cm;
    logic [DW-1:0] s_pc, s_red;
    int n, fault;
    e_pop = 0; e_sreq = 0; e_flush = 0; e_exc = 0; commit_now = 0; sched = 0;
    s_exc = 0; st = 0; e_we = 0; cm = 0; s_pc = 0; s_red = 0; n = 0; fault = -1;
    nwait = m_waiting;
    #3;
    if (!rst) begin
      nwait = 0;
    end else if (m_flush_now) begin
      e_flush = 1; e_exc = m_exc_now; nwait = 0;
    end else begin
      // Retire in order up to (not including) the first faulting slot.
      for (int i = 0; i < 2; i++)
        if (hd_valid[i] && fault < 0) begin
          if (hd_ex[i]) fault = i;
          else begin cm[i] = 1; n++; if (hd_store[i]) st = 1; end
        end
      rdy = !rob_empty && (!hd_valid[0] || hd_done[0]) && (!hd_valid[1] || hd_done[1]);
      if (m_waiting) begin
        e_sreq = 1; commit_now = store_ack;
      end else if (rdy) begin
        if (fault == 0) begin
          sched = 1; s_exc = 1; s_pc = hd_pc[0 +: DW]; s_red = hd_pc[0 +: DW];
        end else if (st) begin
          e_sreq = 1; commit_now = store_ack; nwait = !store_ack;
        end else commit_now = 1;
      end
      if (commit_now) begin
        e_pop = 1; nwait = 0;
        for (int i = 0; i < 2; i++) e_we[i] = cm[i] && (hd_dest[i*RW +: RW] != 0);
        if (fault == 1) begin
          sched = 1; s_exc = 1; s_pc = hd_pc[DW +: DW]; s_red = hd_pc[DW +: DW];
        end else if (hd_valid[0] && hd_mispred[0]) begin
          sched = 1; s_exc = 0; s_red = hd_target;
        end
      end
    end
    chk("rob_pop", 64'(rob_pop), 64'(e_pop));
    chk("rf_we", 64'(rf_we), 64'(e_we));
    chk("store_req", 64'(store_req), 64'(e_sreq));
    chk("flush", 64'(flush), 64'(e_flush));
    chk("exc_valid", 64'(exc_valid), 64'(e_exc));
    chk("retired_cnt", 64'(retired_cnt), 64'(m_cnt));
    chk("redirect_pc", 64'(redirect_pc), 64'(m_redirect));
    chk("exc_epc", 64'(exc_epc), 64'(m_epc));
    for (int i = 0; i < 2; i++)
      if (e_we[i]) begin
        chk("rf_waddr", 64'(rf_waddr[i*RW +: RW]), 64'(hd_dest[i*RW +: RW]));
        chk("rf_wdata", 64'(rf_wdata[i*DW +: DW]), 64'(hd_data[i*DW +: DW]));
      end
    m_new_head = commit_now || sched || e_flush || rob_empty || !rst;
    @(posedge clk);
    if (!rst) begin
      m_waiting = 0; m_flush_now = 0; m_exc_now = 0;
      m_redirect = 0; m_epc = 0; m_cnt = 0;
    end else begin
      m_flush_now = sched;
      if (sched) begin
        m_exc_now = s_exc; m_redirect = s_red;
        if (s_exc) m_epc = s_pc;
      end
      if (commit_now) m_cnt = m_cnt + CW'(n);
      m_waiting = nwait;
    end
    #1;
  endtask

  task automatic load(input logic [1:0] v, input logic [1:0] dn, input logic [1:0] ex,
                      input logic [1:0] mis, input logic [1:0] st,
                      input logic [RW-1:0] d0, input logic [RW-1:0] d1,
                      input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                      input logic [DW-1:0] p0, input logic [DW-1:0] p1,
                      input logic [DW-1:0] tgt);
    rob_empty = 0; hd_valid = v; hd_done = dn; hd_ex = ex; hd_mispred = mis;
    hd_store = st; hd_dest = {d1, d0}; hd_data = {x1, x0}; hd_pc = {p1, p0};
    hd_target = tgt;
  endtask

  task automatic idle(input int n);
    rob_empty = 1; store_ack = 0;
    repeat (n) step();
  endtask

  task automatic gen_head();
    int r;
    rob_empty  = ($urandom_range(0, 9) == 0);
    hd_valid   = {($urandom_range(0, 4) != 0), 1'b1};
    hd_done    = {($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0)};
    hd_ex      = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
    hd_mispred = {1'b0, ($urandom_range(0, 6) == 0)};
    r = $urandom_range(0, 5);
    hd_store   = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b00;
    hd_dest    = {RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7))};
    hd_data    = {$urandom, $urandom};
    hd_pc      = {$urandom, $urandom};
    hd_target  = $urandom;
  endtask

  initial begin
    rst = 0; rob_empty = 1; store_ack = 0;
    hd_valid = 0; hd_done = 0; hd_ex = 0; hd_mispred = 0; hd_store = 0;
    hd_dest = 0; hd_data = 0; hd_pc = 0; hd_target = 0;
    @(posedge clk); #1;
    step(); step();
    chk("reset_cnt", 64'(retired_cnt), 64'd0);
    rst = 1;
    idle(2);

    // Two adds, both done: single-cycle commit of the pair.
    load(2'b11, 2'b11, 0, 0, 0, 5'd3, 5'd4, 32'd5, 32'd7, 32'h100, 32'h104, 0);
    step();
    chk("add_pair_cnt", 64'(retired_cnt), 64'd2);
    idle(1);

    // Slot 1 outstanding for three cycles.
    load(2'b11, 2'b01, 0, 0, 0, 5'd6, 5'd7, 32'd11, 32'd12, 32'h200, 32'h204, 0);
    repeat (3) step();
    hd_done = 2'b11;
    step();
    chk("late_done_cnt", 64'(retired_cnt), 64'd4);
    idle(1);

    // Store in slot 0, ack arrives on the fourth request cycle.
    load(2'b11, 2'b11, 0, 0, 2'b01, 5'd0, 5'd9, 32'h55, 32'h66, 32'h300, 32'h304, 0);
    store_ack = 0;
    repeat (3) step();
    store_ack = 1;
    step();
    idle(1);

    // Slot 1 faults: slot 0 commits alone, then exception flush.
    load(2'b11, 2'b11, 2'b10, 0, 0, 5'd2, 5'd8, 32'h9, 32'hA,
         32'h80000100, 32'h80000104, 0);
    step();
    chk("ex1_flush", 64'(flush), 64'd1);
    chk("ex1_epc", 64'(exc_epc), 64'h80000104);
    idle(2);

    // Slot 0 mispredict: branch and delay slot retire, redirect to target.
    load(2'b11, 2'b11, 0, 2'b01, 0, 5'd0, 5'd5, 32'h1, 32'h2,
         32'h400, 32'h404, 32'hBFC00200);
    step();
    chk("mis_redirect", 64'(redirect_pc), 64'hBFC00200);
    idle(2);

    // Reset while waiting on a store ack.
    load(2'b11, 2'b11, 0, 0, 2'b10, 5'd1, 5'd2, 32'h3, 32'h4, 32'h500, 32'h504, 0);
    store_ack = 0;
    step(); step();
    rst = 0;
    step();
    chk("rst_sreq", 64'(store_req), 64'd0);
    chk("rst_cnt", 64'(retired_cnt), 64'd0);
    rst = 1; rob_empty = 1;
    step();
    idle(1);

    m_new_head = 1;
    for (int k = 0; k < 3000; k++) begin
      if (!m_waiting) begin
        if (m_new_head) gen_head();
        else hd_done = hd_done | 2'($urandom_range(0, 3));
      end
      store_ack = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
